// File: rtl/serial_sub32_pkg.sv
// serial_sub32_pkg: shared ALU width defaults, FSM state encoding and flag bundle
package serial_sub32_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int SLICE_DEF = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef struct packed {
    logic bout;
    logic v;
    logic z;
  } flags_t;
endpackage

// File: rtl/serial_sub32_if.sv
// serial_sub32_if: operand/result valid-ready bus between the ALU and the serial subtractor
interface serial_sub32_if import serial_sub32_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
);
  logic in_valid, in_ready, Bin, out_valid, out_ready, Bout, V, Z;
  logic [WIDTH-1:0] A, B, D;
  modport master (output in_valid, A, B, Bin, out_ready, input in_ready, out_valid, D, Bout, V, Z);
  modport slave (input in_valid, A, B, Bin, out_ready, output in_ready, out_valid, D, Bout, V, Z);
endinterface

// File: rtl/serial_sub32_four_bit_subtractor.sv
// serial_sub32_four_bit_subtractor: 4-bit borrow look-ahead subtractor slice
module serial_sub32_four_bit_subtractor (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_bin,
  output logic [3:0] o_d,
  output logic       o_bout,
  output logic       o_bmsb
);
  logic [3:0] w_g, w_p;
  logic [4:0] w_b;
  // generate borrow where a=0,b=1; propagate an incoming borrow where a==b
  assign w_g = ~i_a & i_b;
  assign w_p = ~(i_a ^ i_b);
  assign w_b[0] = i_bin;
  assign w_b[1] = w_g[0] | (w_p[0] & i_bin);
  assign w_b[2] = w_g[1] | (w_p[1] & w_g[0]) | (&w_p[1:0] & i_bin);
  assign w_b[3] = w_g[2] | (w_p[2] & w_g[1]) | (&w_p[2:1] & w_g[0]) | (&w_p[2:0] & i_bin);
  assign w_b[4] = w_g[3] | (w_p[3] & w_g[2]) | (&w_p[3:2] & w_g[1]) | (&w_p[3:1] & w_g[0]) | (&w_p & i_bin);
  assign o_d = i_a ^ i_b ^ w_b[3:0];
  assign o_bout = w_b[4];
  assign o_bmsb = w_b[3];
endmodule

// File: rtl/serial_sub32.sv
// serial_sub32: multi-cycle A - B - Bin, one 4-bit slice per clock LSB first,
// borrow rippled through a register, valid/ready on both sides.
module serial_sub32 import serial_sub32_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input logic clk,
  input logic rst_n,
  serial_sub32_if.slave s
);
  localparam int STEPS = WIDTH / SLICE;
  localparam int CW = $clog2(STEPS);
  state_t r_state;
  logic [CW-1:0] r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_dout;
  logic [WIDTH-SLICE-1:0] r_d;
  logic r_borrow, r_in_ready, r_out_valid;
  flags_t r_flags;
  logic [SLICE-1:0] w_d;
  logic w_bout, w_bmsb;
  logic [WIDTH-1:0] w_dfull;
  serial_sub32_four_bit_subtractor u_slice (
    .i_a(r_a[SLICE-1:0]), .i_b(r_b[SLICE-1:0]), .i_bin(r_borrow),
    .o_d(w_d), .o_bout(w_bout), .o_bmsb(w_bmsb)
  );
  // operands shift right each step so the current slice is always at the bottom
  assign w_dfull = {w_d, r_d};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_a <= '0;
      r_b <= '0;
      r_d <= '0;
      r_dout <= '0;
      r_borrow <= 1'b0;
      r_flags <= '0;
      r_in_ready <= 1'b1;
      r_out_valid <= 1'b0;
    end else case (r_state)
      IDLE: if (s.in_valid) begin
        r_a <= s.A;
        r_b <= s.B;
        r_borrow <= s.Bin;
        r_cnt <= '0;
        r_in_ready <= 1'b0;
        r_state <= RUN;
      end
      RUN: begin
        r_a <= r_a >> SLICE;
        r_b <= r_b >> SLICE;
        r_d <= w_dfull[WIDTH-1:SLICE];
        r_borrow <= w_bout;
        r_cnt <= r_cnt + 1'b1;
        // last slice: its bit-3 borrow is the borrow into the word MSB
        if (r_cnt == CW'(STEPS - 1)) begin
          r_dout <= w_dfull;
          r_flags <= '{bout: w_bout, v: w_bmsb ^ w_bout, z: w_dfull == '0};
          r_out_valid <= 1'b1;
          r_state <= DONE;
        end
      end
      DONE: if (s.out_ready) begin
        r_out_valid <= 1'b0;
        r_in_ready <= 1'b1;
        r_state <= IDLE;
      end
      default: r_state <= IDLE;
    endcase
  assign s.in_ready = r_in_ready;
  assign s.out_valid = r_out_valid;
  assign s.D = r_dout;
  assign s.Bout = r_flags.bout;
  assign s.V = r_flags.v;
  assign s.Z = r_flags.z;
endmodule

// File: tb/tb_serial_sub32.sv
// tb_serial_sub32: table-driven and scoreboarded checks of the serial subtractor
module tb_serial_sub32;
  typedef struct {
    logic [31:0] a, b;
    logic bin;
    logic [31:0] d;
    logic bout, v, z;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int cyc = 0, n_chk = 0, n_fail = 0, acc_cyc = 0;
  vec_t q[$];
  serial_sub32_if bus();
  serial_sub32 dut (.clk(clk), .rst_n(rst_n), .s(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic bin, logic [31:0] d, logic bo, logic v, logic z);
    vec_t r;
    r.a = a; r.b = b; r.bin = bin; r.d = d; r.bout = bo; r.v = v; r.z = z;
    return r;
  endfunction

  function automatic vec_t model(vec_t v);
    logic [32:0] r;
    r = {1'b0, v.a} - {1'b0, v.b} - {32'd0, v.bin};
    v.d = r[31:0];
    v.bout = r[32];
    v.v = (v.a[31] ^ v.b[31]) & (r[31] ^ v.a[31]);
    v.z = (r[31:0] == 32'd0);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic issue(input vec_t v);
    int t = 0;
    while (!bus.in_ready && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    chk1("in_ready_before_issue", bus.in_ready, 1'b1);
    bus.A = v.a; bus.B = v.b; bus.Bin = v.bin; bus.in_valid = 1'b1;
    @(posedge clk);
    acc_cyc = cyc;
    q.push_back(v);
    #1;
    bus.in_valid = 1'b0;
    bus.A = $urandom; bus.B = $urandom; bus.Bin = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (!bus.out_valid) chk1("in_ready_busy", bus.in_ready, 1'b0);
    end while (!bus.out_valid && n < 20);
    chk("latency", n, 8);
  endtask

  task automatic consume();
    vec_t e;
    if (q.size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL scoreboard: result with no expected entry");
      return;
    end
    e = q.pop_front();
    chk1("out_valid", bus.out_valid, 1'b1);
    chk("D", bus.D, e.d);
    chk1("Bout", bus.Bout, e.bout);
    chk1("V", bus.V, e.v);
    chk1("Z", bus.Z, e.z);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk1("in_ready_idle", bus.in_ready, 1'b1);
    chk1("out_valid_idle", bus.out_valid, 1'b0);
    chk("D_hold_idle", bus.D, e.d);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk1({tag, "_in_ready"}, bus.in_ready, 1'b1);
    chk1({tag, "_out_valid"}, bus.out_valid, 1'b0);
    chk({tag, "_D"}, bus.D, 32'd0);
    chk1({tag, "_Bout"}, bus.Bout, 1'b0);
    chk1({tag, "_V"}, bus.V, 1'b0);
    chk1({tag, "_Z"}, bus.Z, 1'b0);
  endtask

  initial begin
    vec_t tbl[10];
    vec_t v;
    int prev = 0;
    bus.in_valid = 1'b0; bus.A = '0; bus.B = '0; bus.Bin = 1'b0; bus.out_ready = 1'b0;
    tbl[0] = mk(32'd5, 32'd3, 1'b0, 32'h00000002, 1'b0, 1'b0, 1'b0);
    tbl[1] = mk(32'd0, 32'd1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    tbl[2] = mk(32'h80000000, 32'd1, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
    tbl[3] = mk(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0);
    tbl[4] = mk(32'h1234, 32'h1233, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1);
    tbl[5] = mk(32'h12345678, 32'h12345678, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    tbl[6] = mk(32'd0, 32'd0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1);
    tbl[7] = mk(32'hFFFFFFFF, 32'd0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    tbl[8] = mk(32'd0, 32'h80000000, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0);
    tbl[9] = mk(32'd10, 32'd4, 1'b0, 32'h00000006, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      issue(tbl[i]);
      if (i > 0) chk("issue_interval", acc_cyc - prev, 10);
      prev = acc_cyc;
      wait_done();
      consume();
    end
    for (int i = 0; i < 8; i++) begin
      v.a = $urandom; v.b = $urandom; v.bin = 1'($urandom_range(0, 1));
      v = model(v);
      issue(v);
      wait_done();
      consume();
    end
    issue(mk(32'hDEADBEEF, 32'h12345678, 1'b0, 32'hCC796877, 1'b0, 1'b0, 1'b0));
    wait_done();
    repeat (5) begin
      bus.in_valid = 1'b1; bus.A = $urandom; bus.B = $urandom;
      @(posedge clk); #1;
      chk1("bp_out_valid", bus.out_valid, 1'b1);
      chk("bp_D", bus.D, 32'hCC796877);
      chk1("bp_flags", bus.Bout | bus.V | bus.Z, 1'b0);
      chk1("bp_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b0;
    consume();
    @(posedge clk); #1;
    chk1("no_spurious_accept", bus.in_ready, 1'b1);
    v.a = 32'hFFFF0000; v.b = 32'd1; v.bin = 1'b0;
    issue(model(v));
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_run");
    q.delete();
    @(posedge clk); #1;
    chk1("rst_run_hold_in_ready", bus.in_ready, 1'b1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    issue(tbl[9]);
    wait_done();
    consume();
    issue(mk(32'd1, 32'd2, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0));
    wait_done();
    #1 rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_done");
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    issue(tbl[9]);
    wait_done();
    consume();
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end
endmodule
